// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory-access stage.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Widen a byte (low 8 bits of v) or a half (all 16 bits) to 32 bits.
  function automatic logic [31:0] ext_load(input logic [15:0] v, input logic is_half,
                                           input logic uns);
    logic [31:0] r;
    if (is_half) begin
      r = uns ? {16'h0000, v} : {{16{v[15]}}, v};
    end else begin
      r = uns ? {24'h000000, v[7:0]} : {{24{v[7]}}, v[7:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: enables, replicated store data, extended load data, alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection of the read word by the low address bits.
  always_comb begin
    byte_s = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      2'd3:    byte_s = rdata_i[31:24];
      default: byte_s = rdata_i[7:0];
    endcase
    half_s = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Size decode: enables, store replication, load extension, illegal access flag.
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = 32'h0000_0000;
    ldata_o    = rdata_i;
    misalign_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        ldata_o = ext_load({8'h00, byte_s}, 1'b0, uns_i);
      end
      SZ_HALF: begin
        be_o       = 4'b0011 << addr_lo_i;
        wdata_o    = {2{wdata_i[15:0]}};
        ldata_o    = ext_load(half_s, 1'b1, uns_i);
        misalign_o = addr_lo_i[0];
      end
      SZ_WORD: begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        ldata_o    = rdata_i;
        misalign_o = (addr_lo_i != 2'b00);
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: one load/store per start pulse over a req/ack data-memory port,
// with alignment check, ack timeout and registered outputs.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  lsu_state_e  state_q, state_d;
  logic        store_q, store_d, uns_q, uns_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [CW-1:0] tmo_q, tmo_d;

  logic [3:0]  be_s;
  logic [31:0] st_data_s, ld_data_s;
  logic        misalign_s;

  lsu_align u_align (
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .uns_i      (uns_q),
    .wdata_i    (wdata_q),
    .rdata_i    (mem_rdata),
    .be_o       (be_s),
    .wdata_o    (st_data_s),
    .ldata_o    (ld_data_s),
    .misalign_o (misalign_s)
  );

  // Next-state and output decode; done/err default low so they only ever pulse.
  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    tmo_d       = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          store_d = is_store;
          size_d  = size;
          uns_d   = uns;
          addr_d  = addr;
          wdata_d = wdata;
          busy_d  = 1'b1;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (misalign_s) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = store_q;
          mem_addr_d  = addr_q[31:2];
          mem_be_d    = be_s;
          mem_wdata_d = st_data_s;
          tmo_d       = {CW{1'b0}};
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          rdata_d   = store_q ? rdata_q : ld_data_s;
          state_d   = ST_RESP;
        end else if (tmo_q == CW'(TIMEOUT - 1)) begin
          // Last allowed request cycle without ack: abort, rdata keeps its old value.
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      store_q     <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 30'h0000_0000;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      rdata_q     <= 32'h0000_0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;

endmodule
